// File: rtl/parity_frame_checker.sv
// Streaming frame parity checker: XOR-accumulates every data bit of a frame,
// checks the closing parity bit in even/odd mode and holds the result under valid/ready.
module parity_frame_checker #(
  parameter  int WIDTH   = 8,
  parameter  int MAX_LEN = 4,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_par,
  input  logic             odd_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic             out_err,
  output logic             out_ovf,
  output logic [LEN_W-1:0] out_len,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             cnt_clr
);

  typedef enum logic {
    ST_ACCUM  = 1'b0,
    ST_RESULT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_acc;
  logic [LEN_W-1:0]   r_cnt;
  logic               r_mode;
  logic               r_out_parity;
  logic               r_out_err;
  logic               r_out_ovf;
  logic [LEN_W-1:0]   r_out_len;
  logic [CNT_W-1:0]   r_err_cnt;

  logic               w_accept;
  logic               w_acc_next;
  logic [LEN_W-1:0]   w_cnt_next;
  logic               w_mode;
  logic               w_full;
  logic               w_close;
  logic               w_ovf;
  logic               w_err;
  logic               w_err_inc;

  assign in_ready   = (r_state == ST_ACCUM);
  assign out_valid  = (r_state == ST_RESULT);
  assign out_parity = r_out_parity;
  assign out_err    = r_out_err;
  assign out_ovf    = r_out_ovf;
  assign out_len    = r_out_len;
  assign err_cnt    = r_err_cnt;

  // Beat datapath: running parity, beat count and close/check decisions.
  // The mode used for the check is the live input on the first beat, since the latch is not yet loaded.
  always_comb begin
    w_accept   = in_valid && (r_state == ST_ACCUM);
    w_acc_next = r_acc ^ (^in_data);
    w_cnt_next = r_cnt + LEN_W'(1);
    w_mode     = (r_cnt == {LEN_W{1'b0}}) ? odd_mode : r_mode;
    w_full     = (w_cnt_next == LEN_W'(MAX_LEN));
    w_close    = w_accept && (in_last || w_full);
    w_ovf      = w_full && !in_last;
    w_err      = w_ovf | (in_par ^ w_acc_next ^ w_mode);
    w_err_inc  = w_close && w_err && (r_err_cnt != {CNT_W{1'b1}});
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode: close a frame into RESULT, leave on the output handshake.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ACCUM: begin
        if (w_close) begin
          w_state_next = ST_RESULT;
        end else begin
          w_state_next = ST_ACCUM;
        end
      end
      ST_RESULT: begin
        if (out_ready) begin
          w_state_next = ST_ACCUM;
        end else begin
          w_state_next = ST_RESULT;
        end
      end
      default: w_state_next = ST_ACCUM;
    endcase
  end

  // Accumulator, beat count, mode latch and registered result fields.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc        <= 1'b0;
      r_cnt        <= {LEN_W{1'b0}};
      r_mode       <= 1'b0;
      r_out_parity <= 1'b0;
      r_out_err    <= 1'b0;
      r_out_ovf    <= 1'b0;
      r_out_len    <= {LEN_W{1'b0}};
    end else if (w_accept) begin
      if (r_cnt == {LEN_W{1'b0}}) begin
        r_mode <= odd_mode;
      end
      if (w_close) begin
        r_acc        <= 1'b0;
        r_cnt        <= {LEN_W{1'b0}};
        r_out_parity <= w_acc_next;
        r_out_err    <= w_err;
        r_out_ovf    <= w_ovf;
        r_out_len    <= w_cnt_next;
      end else begin
        r_acc <= w_acc_next;
        r_cnt <= w_cnt_next;
      end
    end
  end

  // Saturating error counter; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_cnt <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      r_err_cnt <= {CNT_W{1'b0}};
    end else if (w_err_inc) begin
      r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

endmodule
